// File: rtl/rv_ctrl_fsm_if.sv
// rv_ctrl_fsm_if: decoder/datapath/memory handshake bundle of the RV32I control sequencer
interface rv_ctrl_fsm_if;
  logic [3:0]  itype;
  logic        br_taken;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_load;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        pc_en;
  logic [3:0]  pc_type;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        fault;
  logic [1:0]  fault_code;
  modport master (
    output itype, br_taken, imem_ack, dmem_ack,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_type, state, instret, fault, fault_code
  );
  modport slave (
    input  itype, br_taken, imem_ack, dmem_ack,
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_type, state, instret, fault, fault_code
  );
endinterface

// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB) with retired count.
// Define RV_CTRL_TIMEOUT_EN to fault on memory handshakes that wait TIMEOUT_CYCLES without ack.
module rv_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic       clk,
  input logic       rst,
  rv_ctrl_fsm_if.slave bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;
  localparam logic [3:0] T_LOAD = 4'd0, T_SEQ = 4'd1, T_STORE = 4'd2, T_BRNCH = 4'd6, T_MAX = 4'd8;
  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_chk
    $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
  end
  state_t      state_q, state_d;
  logic [3:0]  type_q, type_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [31:0] instret_q;
  logic        ir_load, pc_en;
  logic [3:0]  pc_type;
`ifdef RV_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
`endif
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    fault_code_d = fault_code_q;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_type      = type_q;
    case (state_q)
      FETCH: if (bus.imem_ack) begin
        ir_load = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        type_d       = bus.itype;
        state_d      = bus.itype > T_MAX ? FAULT : EXEC;
        fault_code_d = bus.itype > T_MAX ? 2'b01 : fault_code_q;
      end
      EXEC: begin
        state_d = (type_q == T_LOAD || type_q == T_STORE) ? MEM : type_q == T_BRNCH ? FETCH : WB;
        pc_en   = type_q == T_BRNCH;
        pc_type = type_q == T_BRNCH ? (bus.br_taken ? T_BRNCH : T_SEQ) : type_q;
      end
      MEM: if (bus.dmem_ack) begin
        state_d = type_q == T_STORE ? FETCH : WB;
        pc_en   = type_q == T_STORE;
      end
      WB: begin
        pc_en   = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FAULT;
    endcase
`ifdef RV_CTRL_TIMEOUT_EN
    waiting = (state_q == FETCH && !bus.imem_ack) || (state_q == MEM && !bus.dmem_ack);
    if (waiting && cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
      state_d      = FAULT;
      fault_code_d = 2'b10;
    end
    // Any exit from a wait state, including into the next one, restarts the count.
    cnt_d = (waiting && state_d != FAULT) ? cnt_q + 1'b1 : '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      type_q       <= '0;
      fault_code_q <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      fault_code_q <= fault_code_d;
      instret_q    <= instret_q + 32'(pc_en);
    end
  end
`ifdef RV_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
  assign bus.state      = state_q;
  assign bus.imem_req   = state_q == FETCH;
  assign bus.dmem_req   = state_q == MEM;
  assign bus.dmem_we    = state_q == MEM && type_q == T_STORE;
  assign bus.rf_we      = state_q == WB;
  assign bus.fault      = state_q == FAULT;
  assign bus.fault_code = fault_code_q;
  assign bus.instret    = instret_q;
  assign bus.ir_load    = ir_load;
  assign bus.pc_en      = pc_en;
  assign bus.pc_type    = pc_en && state_q == MEM ? T_STORE : pc_type;
endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// tb_rv_ctrl_fsm: scoreboard bench; issue() queues each retirement, a monitor matches pc_en strobes.
module tb_rv_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int total = 0, bad = 0, cyc = 0, ret = 0;
  typedef struct {
    int         cyc;
    logic [3:0] pt;
    logic       rf;
    logic       we;
    int         nreq;
  } exp_t;
  exp_t q[$];
  rv_ctrl_fsm_if bus();
  rv_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Called at the falling edge of a FETCH cycle; drives one instruction to retirement.
  task automatic issue(input logic [3:0] it, input logic br, input int iw, input int dw, input int lat,
                       input logic [3:0] pt, input logic rf, input logic we, input int nreq);
    exp_t e;
    e.cyc = cyc + lat + iw + dw;
    e.pt = pt;
    e.rf = rf;
    e.we = we;
    e.nreq = nreq;
    q.push_back(e);
    bus.itype = it;
    bus.br_taken = br;
    for (int k = 0; k <= lat + iw + dw; k++) begin
      bus.imem_ack = k >= iw;
      bus.dmem_ack = k >= 3 + iw + dw;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask
  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    ret = 0;
    chk_en = 1'b1;
  endtask
  initial begin
    int nreq, nir;
    exp_t e;
    nreq = 0;
    nir = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!chk_en) begin
        nreq = 0;
        nir = 0;
      end else begin
        chk("instret", bus.instret, ret);
        if (bus.dmem_req) begin
          nreq++;
          if (q.size() > 0) chk("dmem_we", bus.dmem_we, q[0].we);
        end
        if (bus.ir_load) nir++;
        if (bus.rf_we) chk("rf_we_with_pc_en", bus.pc_en, 1);
        if (bus.pc_en) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pc_en: got pc_en=1 want 0 (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("pc_en_cycle", cyc, e.cyc);
            chk("pc_type", bus.pc_type, e.pt);
            chk("rf_we", bus.rf_we, e.rf);
            chk("dmem_req_cycles", nreq, e.nreq);
            chk("ir_load_count", nir, 1);
          end
          ret++;
          nreq = 0;
          nir = 0;
        end
      end
    end
  end
  initial begin
    int n;
    bus.itype = 4'd0;
    bus.br_taken = 1'b0;
    do_reset();
    #2;
    chk("rst_state", bus.state, 0);
    chk("rst_imem_req", bus.imem_req, 1);
    chk("rst_instret", bus.instret, 0);
    chk("rst_strobes", {bus.ir_load, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_en}, 0);
    chk("rst_pc_type", bus.pc_type, 0);
    chk("rst_fault", {bus.fault, bus.fault_code}, 0);
    @(negedge clk);
    issue(4'd3, 0, 0, 0, 3, 4'd3, 1, 0, 0);
    issue(4'd1, 0, 0, 0, 3, 4'd1, 1, 0, 0);
    issue(4'd4, 0, 0, 0, 3, 4'd4, 1, 0, 0);
    issue(4'd5, 0, 0, 0, 3, 4'd5, 1, 0, 0);
    issue(4'd7, 0, 0, 0, 3, 4'd7, 1, 0, 0);
    issue(4'd8, 0, 0, 0, 3, 4'd8, 1, 0, 0);
    issue(4'd0, 0, 0, 3, 4, 4'd0, 1, 0, 4);
    issue(4'd2, 0, 0, 0, 3, 4'd2, 0, 1, 1);
    issue(4'd2, 0, 2, 2, 3, 4'd2, 0, 1, 3);
    issue(4'd6, 0, 0, 0, 2, 4'd1, 0, 0, 0);
    issue(4'd6, 1, 0, 0, 2, 4'd6, 0, 0, 0);
    issue(4'd3, 0, 100, 0, 3, 4'd3, 1, 0, 0);
    #2;
    chk("instret_batch", bus.instret, 12);
    chk("pc_type_hold", bus.pc_type, 3);
    @(negedge clk);
    bus.itype = 4'd3;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    do_reset();
    #2;
    chk("midrst_state", bus.state, 0);
    chk("midrst_instret", bus.instret, 0);
    chk("midrst_pc_en", bus.pc_en, 0);
    @(negedge clk);
    bus.itype = 4'd12;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    #2;
    chk("illegal_state", bus.state, 5);
    chk("illegal_fault", bus.fault, 1);
    chk("illegal_code", bus.fault_code, 2'b01);
    chk("illegal_imem_req", bus.imem_req, 0);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("fault_sticky", bus.state, 5);
    chk("fault_no_req", {bus.imem_req, bus.dmem_req, bus.rf_we}, 0);
    @(negedge clk);
`ifdef RV_CTRL_TIMEOUT_EN
    do_reset();
    n = 0;
    while (bus.state != 3'd5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 256);
    chk("timeout_code", bus.fault_code, 2'b10);
    do_reset();
    issue(4'd3, 0, 255, 0, 3, 4'd3, 1, 0, 0);
    #2;
    chk("ack_at_limit_no_fault", bus.fault, 0);
`else
    do_reset();
    issue(4'd3, 0, 300, 0, 3, 4'd3, 1, 0, 0);
    #2;
    chk("long_wait_no_fault", {bus.fault, bus.fault_code}, 0);
    n = 0;
`endif
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100000");
    $fatal(1, "watchdog");
  end
endmodule
